// File: rtl/pt_check_pkg.sv
// Shared types and the printable-byte classifier for the plaintext checker.
package pt_check_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_LEN,
    WT_LEN,
    RD_BYTE,
    WT_BYTE,
    FIN
  } state_t;

  localparam logic [7:0] PRINT_LO = 8'h20;
  localparam logic [7:0] PRINT_HI = 8'h7E;

  function automatic logic is_printable(input logic [7:0] b);
    return (b >= PRINT_LO) && (b <= PRINT_HI);
  endfunction

endpackage

// File: rtl/pt_check.sv
// Scans a length-prefixed string in a synchronous-read memory and reports whether all bytes are printable.
// Optional macro PT_CHECK_EARLY_EXIT_EN stops the scan at the first non-printable byte.
module pt_check
  import pt_check_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  output logic       rdy,
  output logic [7:0] pt_addr,
  input  logic [7:0] pt_rddata,
  output logic [7:0] len,
  output logic       valid,
  output logic [7:0] fail_addr
);

  state_t     state;
  logic [7:0] idx;
  logic       stop_early;

`ifdef PT_CHECK_EARLY_EXIT_EN
  assign stop_early = !is_printable(pt_rddata);
`else
  assign stop_early = 1'b0;
`endif

  // Memory returns data the cycle after the address is presented, so each
  // location costs an RD/WT state pair.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= 8'd0;
      rdy       <= 1'b1;
      pt_addr   <= 8'd0;
      len       <= 8'd0;
      valid     <= 1'b0;
      fail_addr <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (en) begin
            state     <= RD_LEN;
            rdy       <= 1'b0;
            pt_addr   <= 8'd0;
            len       <= 8'd0;
            valid     <= 1'b0;
            fail_addr <= 8'd0;
          end
        end
        RD_LEN: state <= WT_LEN;
        WT_LEN: begin
          len <= pt_rddata;
          if (pt_rddata == 8'd0) begin
            state <= FIN;
          end else begin
            state   <= RD_BYTE;
            idx     <= 8'd1;
            pt_addr <= 8'd1;
          end
        end
        RD_BYTE: state <= WT_BYTE;
        WT_BYTE: begin
          if (!is_printable(pt_rddata) && (fail_addr == 8'd0))
            fail_addr <= idx;
          // Compare before incrementing so a 255-byte string never wraps.
          if ((idx == len) || stop_early) begin
            state   <= FIN;
            pt_addr <= 8'd0;
          end else begin
            state   <= RD_BYTE;
            idx     <= idx + 8'd1;
            pt_addr <= idx + 8'd1;
          end
        end
        FIN: begin
          valid <= (fail_addr == 8'd0);
          rdy   <= 1'b1;
          state <= IDLE;
        end
        default: begin
          state   <= IDLE;
          rdy     <= 1'b1;
          pt_addr <= 8'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pt_check.sv
// Randomised and directed bench for pt_check against a run-level reference model.
module tb_pt_check;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b0;
  logic       rdy;
  logic [7:0] pt_addr;
  logic [7:0] pt_rddata;
  logic [7:0] len;
  logic       valid;
  logic [7:0] fail_addr;

  pt_check dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .rdy      (rdy),
    .pt_addr  (pt_addr),
    .pt_rddata(pt_rddata),
    .len      (len),
    .valid    (valid),
    .fail_addr(fail_addr)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [256];
  always @(posedge clk) pt_rddata <= mem[pt_addr];

  int vectors = 0;
  int errors  = 0;
  logic chk_on = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: on acceptance the whole run is predicted as a queue of
  // per-cycle addresses, plus the final len/valid/fail_addr results.
  int unsigned q[$];
  logic [7:0]  e_len = 8'd0, e_fail = 8'd0, p_len, p_fail;
  logic        e_valid = 1'b0, p_valid;

  task automatic predict();
    int l, fb, stop;
    l  = int'(mem[0]);
    fb = 0;
    for (int i = 1; i <= l; i++)
      if (((mem[i] < 8'h20) || (mem[i] > 8'h7E)) && fb == 0) fb = i;
    stop = l;
`ifdef PT_CHECK_EARLY_EXIT_EN
    if (fb != 0) stop = fb;
`endif
    q.push_back(0);
    q.push_back(0);
    for (int i = 1; i <= stop; i++) begin
      q.push_back(i);
      q.push_back(i);
    end
    q.push_back(0);
    p_len   = 8'(l);
    p_valid = (fb == 0);
    p_fail  = 8'(fb);
  endtask

  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      e_len = 8'd0; e_valid = 1'b0; e_fail = 8'd0;
    end else if (q.size() == 0) begin
      if (en) begin
        predict();
        e_len = 8'd0; e_valid = 1'b0; e_fail = 8'd0;
      end
    end else begin
      void'(q.pop_front());
      if (q.size() == 0) begin
        e_len = p_len; e_valid = p_valid; e_fail = p_fail;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("rdy", 32'(rdy), 32'(q.size() == 0));
      chk("pt_addr", 32'(pt_addr), (q.size() == 0) ? 32'd0 : 32'(q[0]));
      if (q.size() == 0) begin
        chk("len", 32'(len), 32'(e_len));
        chk("valid", 32'(valid), 32'(e_valid));
        chk("fail_addr", 32'(fail_addr), 32'(e_fail));
      end
    end
  end

  typedef logic [7:0] bq_t[$];
  task automatic load(input bq_t d);
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    for (int i = 0; i < d.size(); i++) mem[i] = d[i];
  endtask

  int last_addr;

  // Starts one run with a single-cycle en pulse and counts busy cycles.
  task automatic run(input int pulse_at, input int rst_at, output int busy);
    int guard;
    guard = 0;
    while (rdy !== 1'b1 && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    chk("idle_wait", 32'(guard < 2000), 32'd1);
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    busy = 0;
    last_addr = 0;
    while (rdy !== 1'b1 && busy < 1000) begin
      busy++;
      if (pt_addr != 8'd0) last_addr = int'(pt_addr);
      if (pulse_at != 0 && busy == pulse_at) en = 1'b1;
      if (pulse_at != 0 && busy == pulse_at + 1) en = 1'b0;
      if (rst_at != 0 && busy == rst_at) begin
        chk("pre_rst_addr", 32'(pt_addr), 32'd4);
        rst = 1'b1;
      end
      @(negedge clk);
    end
    en  = 1'b0;
    rst = 1'b0;
    chk("busy_bound", 32'(busy < 1000), 32'd1);
  endtask

  int b;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_rdy", 32'(rdy), 32'd1);
    chk("rst_addr", 32'(pt_addr), 32'd0);
    chk("rst_len", 32'(len), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_fail", 32'(fail_addr), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk_on = 1'b1;

    load('{8'd3, 8'h61, 8'h62, 8'h63});
    run(0, 0, b);
    chk("abc_busy", 32'(b), 32'd9);
    chk("abc_len", 32'(len), 32'd3);
    chk("abc_valid", 32'(valid), 32'd1);
    chk("abc_fail", 32'(fail_addr), 32'd0);

    load('{8'd0});
    run(0, 0, b);
    chk("empty_busy", 32'(b), 32'd3);
    chk("empty_len", 32'(len), 32'd0);
    chk("empty_valid", 32'(valid), 32'd1);

    load('{8'd5, 8'h41, 8'h0A, 8'h42, 8'h7F, 8'h43});
    run(0, 0, b);
`ifdef PT_CHECK_EARLY_EXIT_EN
    chk("bad2_busy", 32'(b), 32'd7);
`else
    chk("bad2_busy", 32'(b), 32'd13);
`endif
    chk("bad2_valid", 32'(valid), 32'd0);
    chk("bad2_fail", 32'(fail_addr), 32'd2);
    chk("bad2_len", 32'(len), 32'd5);

    load('{8'd4, 8'h20, 8'h7E, 8'h1F, 8'h7F});
    run(0, 0, b);
    chk("edge_fail", 32'(fail_addr), 32'd3);
    chk("edge_valid", 32'(valid), 32'd0);
    load('{8'd2, 8'h20, 8'h7E});
    run(0, 0, b);
    chk("edge_ok_valid", 32'(valid), 32'd1);
    chk("edge_ok_fail", 32'(fail_addr), 32'd0);

    for (int i = 0; i < 256; i++) mem[i] = 8'h61;
    mem[0] = 8'd255;
    run(100, 0, b);
    chk("long_busy", 32'(b), 32'd513);
    chk("long_last_addr", 32'(last_addr), 32'd255);
    chk("long_valid", 32'(valid), 32'd1);
    chk("long_len", 32'(len), 32'd255);

    load('{8'd8, 8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h47, 8'h48});
    run(0, 9, b);
    chk("mid_rst_rdy", 32'(rdy), 32'd1);
    chk("mid_rst_addr", 32'(pt_addr), 32'd0);
    chk("mid_rst_valid", 32'(valid), 32'd0);
    chk("mid_rst_len", 32'(len), 32'd0);
    run(0, 0, b);
    chk("after_rst_busy", 32'(b), 32'd19);
    chk("after_rst_valid", 32'(valid), 32'd1);

    // en held high: back-to-back runs, each checked by the model.
    load('{8'd2, 8'h30, 8'h05});
    en = 1'b1;
    repeat (30) @(negedge clk);
    en = 1'b0;

    for (int r = 0; r < 40; r++) begin
      int l;
      l = $urandom_range(0, 24);
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
      mem[0] = 8'(l);
      for (int i = 1; i <= l; i++)
        mem[i] = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 255))
                                             : 8'($urandom_range(32, 126));
      run(($urandom_range(0, 1) == 1) ? 2 : 0, 0, b);
    end

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
